serial_borrow_subtractor: RTL and testbench
===========================================

# serial_borrow_subtractor

Multi-cycle N-bit subtractor that computes D = A − B − Bin by processing W bits per clock, least-significant chunk first, and carries the borrow between chunks in a register. It is the inverse-operation companion to the combinational adders in the arithmetic library. It fits datapaths that trade latency for a narrow W-bit subtract slice, and it uses a start/busy/done handshake toward the controlling FSM.

## Interface
- N, default 16: operand and result width in bits.
- W, default 4: chunk width processed per cycle. N must be an exact multiple of W. K = N/W is the number of chunk cycles.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request a subtraction; sampled only in IDLE or DONE.
- A  input  N  minuend; sampled with start.
- B  input  N  subtrahend; sampled with start.
- Bin  input  1  borrow-in; sampled with start.
- D  output  N  difference A − B − Bin, modulo 2^N.
- Bout  output  1  final borrow out; 1 when A < B + Bin as unsigned values.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse when D and Bout are valid and newly updated.
- ovf  output  1  signed overflow flag; present only with SBS_SIGNED_OVF_EN.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE with start=1: the block latches A, B and Bin into internal operand registers, loads the borrow register with Bin, clears the chunk index to 0, and moves to BUSY.
- IDLE with start=0: the block stays in IDLE.
- BUSY, each cycle, at chunk index i:
  - diff = A[i*W +: W] − B[i*W +: W] − borrow, computed at W+1 bits.
  - The low W bits go to the internal result register at chunk i.
  - The borrow register takes the MSB of the W+1-bit difference.
  - The index increments.
- BUSY, at i = K−1: the block updates the chunk as above, copies the full result register to D and the final borrow to Bout, updates ovf if present, and moves to DONE.
- DONE lasts exactly one cycle. With start=1 in that cycle, the block behaves as IDLE with start=1 (back-to-back operation). Otherwise it moves to IDLE.
- start during BUSY is ignored, and the latched operands are unaffected.
- A, B and Bin may change freely after the start-sampling edge.
- D, Bout and ovf hold the last completed result until the next completion. They never show partial results.
- Arithmetic is unsigned modulo 2^N.
- Bout equals the borrow out of the top chunk.
- Bout equals NOT of the carry of A + ~B + ~Bin.

## Timing
- Reset values: D=0, Bout=0, busy=0, done=0, ovf=0. The FSM is in IDLE, the index is 0 and the borrow register is 0.
- Reset asserted mid-operation aborts immediately. All outputs return to their reset values, and the partial result is discarded.
- Edge numbering: start is sampled high at edge 0.
  - busy is high after edge 0.
  - Chunk i is written at edge i+1.
  - At edge K, D and Bout update, busy falls and done rises.
  - At edge K+1, done falls.
- Latency is K cycles from the start-sampling edge to done; with defaults, 4 cycles.
- Throughput with back-to-back start is one result every K+1 cycles.
- In the DONE cycle, busy=0 and done=1.
- With W=N (K=1), there is a single BUSY cycle, and all rules above still hold.

## Configuration
- SBS_SIGNED_OVF_EN defined:
  - Port ovf exists.
  - At completion, ovf = (A[N−1] ≠ B[N−1]) AND (D[N−1] ≠ A[N−1]), using the latched A and B and the new D.
  - ovf holds with D and is reset to 0.
  - Bin does not enter the formula beyond its effect on D.
- SBS_SIGNED_OVF_EN undefined: port ovf is absent. There is no sign logic, and the rest of the behaviour is identical.

## Test plan
All cases use N=16, W=4.
- Reset and basic subtract: reset, then A=0x1234, B=0x0234, Bin=0, start → at edge 4, D=0x1000, Bout=0, done high for exactly one cycle, busy high for cycles 1–4.
- Borrow ripple across all chunks, two cases:
  - A=0x1000, B=0x0001 → D=0x0FFF, Bout=0.
  - A=0x0000, B=0x0001 → D=0xFFFF, Bout=1.
- Borrow-in: A=0x0005, B=0x0005, Bin=1 → D=0xFFFF, Bout=1. Operands change to random values after edge 0, and the result is unaffected.
- Handshake boundaries:
  - start is held high continuously → new results complete at edges 4, 9 and 14.
  - start is pulsed at edge 2 during BUSY → ignored, and D is the original result.
  - D stays unchanged between done pulses.
- Reset mid-operation: rst is asserted after edge 2 of A=0xFFFF, B=0x0001 → D=0, Bout=0, busy=0 and no done pulse. A fresh start afterwards gives D=0xFFFE.
- Overflow (macro defined):
  - A=0x8000, B=0x0001 → D=0x7FFF, ovf=1.
  - A=0x0003, B=0x0001 → ovf=0.
  - With the macro undefined, the build has no ovf port.

Source files
------------

// File: rtl/serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_borrow_subtractor
// Purpose  : Multi-cycle N-bit subtractor D = A - B - Bin. Processes W bits
//            per clock, starting with the least-significant chunk. The borrow
//            is carried between chunks in a register. Uses a start/busy/done
//            handshake.
// Ports    : clk   - system clock, rising edge
//            rst   - asynchronous active-high reset
//            start - request; sampled only in IDLE or DONE
//            A, B  - N-bit minuend / subtrahend, sampled with start
//            Bin   - borrow-in, sampled with start
//            D     - N-bit difference (holds last completed result)
//            Bout  - final borrow out (A < B + Bin, unsigned)
//            busy  - high while chunks are being processed
//            done  - one-cycle pulse when D/Bout are newly valid
//            ovf   - signed overflow flag (only with SBS_SIGNED_OVF_EN)
// Config   : `define SBS_SIGNED_OVF_EN adds the ovf port and its sign logic.
// Revision : 1.0 - initial release
// ============================================================================
module serial_borrow_subtractor #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic [N-1:0] D,
  output logic         Bout,
  output logic         busy,
  output logic         done
`ifdef SBS_SIGNED_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int c_K  = N / W;
  localparam int c_IW = (c_K > 1) ? $clog2(c_K) : 1;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_res;
  logic            r_borrow;
  logic [c_IW-1:0] r_idx;
  logic [N-1:0]    r_d;
  logic            r_bout;

  logic            w_load;
  logic            w_last;
  logic [W-1:0]    w_a_chunk;
  logic [W-1:0]    w_b_chunk;
  logic [W:0]      w_diff;
  logic [N-1:0]    w_res_nxt;

  // A new operation may be accepted in IDLE and in the one-cycle DONE state.
  assign w_load = start && ((r_state == c_IDLE) || (r_state == c_DONE));
  assign w_last = (r_idx == c_IW'(c_K - 1));

  assign w_a_chunk = r_a[r_idx*W +: W];
  assign w_b_chunk = r_b[r_idx*W +: W];

  // The subtraction is W+1 bits wide. A negative chunk result wraps, which sets
  // the MSB, so the MSB is the borrow into the next chunk.
  assign w_diff = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{W{1'b0}}, r_borrow};

  // This is the result register with the current chunk merged in. Using it at
  // the last chunk means D is complete in the same edge that finishes it.
  always_comb begin
    w_res_nxt = r_res;
    w_res_nxt[r_idx*W +: W] = w_diff[W-1:0];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  w_state_nxt = start  ? c_BUSY : c_IDLE;
      c_BUSY:  w_state_nxt = w_last ? c_DONE : c_BUSY;
      c_DONE:  w_state_nxt = start  ? c_BUSY : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (r_state == c_BUSY);
    done = (r_state == c_DONE);
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_idx    <= '0;
      r_d      <= '0;
      r_bout   <= 1'b0;
    end else if (w_load) begin
      r_a      <= A;
      r_b      <= B;
      r_borrow <= Bin;
      r_idx    <= '0;
    end else if (r_state == c_BUSY) begin
      r_res    <= w_res_nxt;
      r_borrow <= w_diff[W];
      r_idx    <= w_last ? '0 : r_idx + c_IW'(1);
      if (w_last) begin
        r_d    <= w_res_nxt;
        r_bout <= w_diff[W];
      end
    end
  end

  assign D    = r_d;
  assign Bout = r_bout;

`ifdef SBS_SIGNED_OVF_EN
  logic r_ovf;

  // Signed overflow occurs only when the operand signs differ and the result
  // sign does not match the minuend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_load && (r_state == c_BUSY) && w_last) begin
      r_ovf <= (r_a[N-1] != r_b[N-1]) && (w_res_nxt[N-1] != r_a[N-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_borrow_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_borrow_subtractor
// Purpose  : Self-checking bench for serial_borrow_subtractor (N=16, W=4).
//            Expected values come from plain integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_borrow_subtractor;

  localparam int N = 16;
  localparam int W = 4;
  localparam int K = N / W;

  logic          clk;
  logic          rst;
  logic          start;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          Bin;
  logic [N-1:0]  D;
  logic          Bout;
  logic          busy;
  logic          done;
`ifdef SBS_SIGNED_OVF_EN
  logic          ovf;
`endif

  int n_assert;
  int n_fail;

  serial_borrow_subtractor #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .D     (D),
    .Bout  (Bout),
    .busy  (busy),
    .done  (done)
`ifdef SBS_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: integer subtraction, wrapped modulo 2^16.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                                output logic [15:0] d, output logic bo, output logic ov);
    int diff;
    diff = int'(a) - int'(b) - int'(bin);
    d    = 16'((diff + 65536) % 65536);
    bo   = (diff < 0);
    ov   = (a[15] != b[15]) && (d[15] != a[15]);
  endfunction

  // One full operation with cycle-exact checks. When pulse_at is 1..K, start
  // is raised with junk operands so that it is sampled at that BUSY edge.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic bin, input int pulse_at);
    logic [15:0] ed;
    logic        eb;
    logic        eo;
    logic [15:0] prev;
    model(a, b, bin, ed, eb, eo);
    prev = D;
    @(negedge clk);
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    for (int k = 1; k <= K; k++) begin
      if (k == pulse_at) begin
        @(negedge clk);
        start = 1'b1; A = 16'($urandom); B = 16'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (k < K) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_nodone"}, 32'(done), 32'd0);
        chk({tag, "_dhold"}, 32'(D), 32'(prev));
      end else begin
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busyoff"}, 32'(busy), 32'd0);
        chk({tag, "_D"}, 32'(D), 32'(ed));
        chk({tag, "_Bout"}, 32'(Bout), 32'(eb));
`ifdef SBS_SIGNED_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
      end
    end
    @(posedge clk); #1;
    chk({tag, "_donefall"}, 32'(done), 32'd0);
    chk({tag, "_Dkeep"}, 32'(D), 32'(ed));
  endtask

  logic [15:0] opa [3];
  logic [15:0] opb [3];
  logic        opc [3];
  logic [15:0] xd;
  logic        xb;
  logic        xo;
  int          j;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef SBS_SIGNED_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    run_op("basic", 16'h1234, 16'h0234, 1'b0, 0);
    run_op("ripple1", 16'h1000, 16'h0001, 1'b0, 0);
    run_op("ripple2", 16'h0000, 16'h0001, 1'b0, 0);
    run_op("bin", 16'h0005, 16'h0005, 1'b1, 0);
    run_op("ignore", 16'h9876, 16'h1111, 1'b0, 2);
`ifdef SBS_SIGNED_OVF_EN
    run_op("ovf1", 16'h8000, 16'h0001, 1'b0, 0);
    run_op("ovf0", 16'h0003, 16'h0001, 1'b0, 0);
`endif

    // Random operations
    for (int r = 0; r < 8; r++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 0);
    end

    // Back-to-back: start is held high, so completions land at edges 4, 9 and 14.
    for (int i = 0; i < 3; i++) begin
      opa[i] = 16'($urandom); opb[i] = 16'($urandom); opc[i] = 1'($urandom);
    end
    @(negedge clk);
    A = opa[0]; B = opb[0]; Bin = opc[0]; start = 1'b1;
    @(posedge clk); #1;
    A = opa[1]; B = opb[1]; Bin = opc[1];
    j = 0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (e == 5)  begin A = opa[2]; B = opb[2]; Bin = opc[2]; end
      if (e == 10) begin A = 16'($urandom); B = 16'($urandom); end
      if (e == 14) start = 1'b0;
      if (e == 4 || e == 9 || e == 14) begin
        model(opa[j], opb[j], opc[j], xd, xb, xo);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_busy", 32'(busy), 32'd0);
        chk("b2b_D", 32'(D), 32'(xd));
        chk("b2b_Bout", 32'(Bout), 32'(xb));
        j++;
      end else begin
        chk("b2b_nodone", 32'(done), 32'd0);
        chk("b2b_busyon", 32'(busy), 32'd1);
      end
    end
    @(posedge clk); #1;
    chk("b2b_idle", 32'(done), 32'd0);
    chk("b2b_idlebusy", 32'(busy), 32'd0);

    // Reset mid-operation
    @(negedge clk);
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_D", 32'(D), 32'd0);
    chk("mid_Bout", 32'(Bout), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("mid_nodone", 32'(done), 32'd0);
      chk("mid_nobusy", 32'(busy), 32'd0);
    end
    run_op("after_rst", 16'hFFFF, 16'h0001, 1'b0, 0);

    // The result holds while idle.
    xd = D;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_hold", 32'(D), 32'(xd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
